// File: rtl/riscv_unrn_mtimer.sv
// Machine timer: 64-bit mtime with prescaler, NUM_CMP mtimecmp channels and
// level-sensitive MTIP lines, exposed as a one-cycle-latency bus slave.
module riscv_unrn_mtimer #(
  parameter int unsigned NUM_CMP    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [63:0]        mtime_o,
  output logic [NUM_CMP-1:0] mtip_o
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp [NUM_CMP];
  logic [31:0]           hi_shadow;
  logic                  en;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;

  logic [31:0] off;
  logic [4:0]  cmp_word;
  logic [3:0]  cmp_idx;
  logic        cmp_hi;
  logic        sel_ctrl, sel_lo, sel_hi, sel_cmp, dec_err;
  logic        wr, rd;
  logic [31:0] rd_data;

  assign off      = req_addr - BASE_ADDR;
  // Word index relative to the first compare register; LSB picks the half.
  assign cmp_word = off[6:2] - 5'd3;
  assign cmp_idx  = cmp_word[4:1];
  assign cmp_hi   = cmp_word[0];

  assign sel_ctrl = (off == 32'h0);
  assign sel_lo   = (off == 32'h4);
  assign sel_hi   = (off == 32'h8);
  assign sel_cmp  = (off >= 32'hC) && (off < 32'(12 + 8 * NUM_CMP));
  assign dec_err  = (req_addr[1:0] != 2'b00) || !(sel_ctrl || sel_lo || sel_hi || sel_cmp);

  assign wr   = req_valid && req_we && !dec_err;
  assign rd   = req_valid && !req_we && !dec_err;
  assign tick = en && (pcnt == div);

  always_comb begin
    rd_data = '0;
    if (sel_ctrl) begin
      rd_data[0]                = en;
      rd_data[8 +: PRESCALE_W]  = div;
    end else if (sel_lo) begin
      rd_data = mtime[31:0];
    end else if (sel_hi) begin
      rd_data = hi_shadow;
    end else if (sel_cmp) begin
      for (int unsigned i = 0; i < NUM_CMP; i++) begin
        if (cmp_idx == 4'(i)) rd_data = cmp_hi ? mtimecmp[i][63:32] : mtimecmp[i][31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      en        <= 1'b1;
      div       <= '0;
      pcnt      <= '0;
      mtime     <= '0;
      hi_shadow <= '0;
      mtip_o    <= '0;
      for (int unsigned i = 0; i < NUM_CMP; i++) mtimecmp[i] <= '1;
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= req_valid && dec_err;
      rsp_rdata <= rd ? rd_data : '0;

      if (wr && sel_ctrl) begin
        en   <= req_wdata[0];
        div  <= req_wdata[8 +: PRESCALE_W];
        pcnt <= '0;
      end else if (!en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      // A bus write to either half suppresses the increment for that cycle.
      if (wr && sel_lo)      mtime[31:0]  <= req_wdata;
      else if (wr && sel_hi) mtime[63:32] <= req_wdata;
      else if (tick)         mtime        <= mtime + 64'd1;

      if (wr && sel_hi)      hi_shadow <= req_wdata;
      else if (rd && sel_lo) hi_shadow <= mtime[63:32];

      for (int unsigned i = 0; i < NUM_CMP; i++) begin
        if (wr && sel_cmp && cmp_idx == 4'(i)) begin
          if (cmp_hi) mtimecmp[i][63:32] <= req_wdata;
          else        mtimecmp[i][31:0]  <= req_wdata;
        end
        mtip_o[i] <= (mtime >= mtimecmp[i]);
      end
    end
  end

  assign mtime_o = mtime;

endmodule

// File: doc/riscv_unrn_mtimer.md
# riscv_unrn_mtimer

Memory-mapped machine timer for the RISC-V UNRN core: a 64-bit `mtime` counter with programmable prescaler and `NUM_CMP` independent 64-bit `mtimecmp` channels, each driving a level-sensitive machine timer interrupt (`mip.MTIP`, cause `M_TIMER_INT`). It sits on the data-memory bus at `BASE_ADDR`, generalising the fixed single-comparator map at 0x8004–0x8010. It adds channel count, prescaling, an enable control, atomic 64-bit reads and decode-error reporting.

## Interface
- `NUM_CMP`, 1 — number of compare channels/interrupt lines (1..8).
- `BASE_ADDR`, 32'h0000_8000 — base of the register window.
- `PRESCALE_W`, 8 — prescaler divisor width.
- `clk` input 1 — single clock; all state on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `req_valid` input 1 — bus request strobe, one cycle per access.
- `req_we` input 1 — 1 = write, 0 = read.
- `req_addr` input 32 — byte address, word-aligned.
- `req_wdata` input 32 — write data (full-word writes only).
- `rsp_valid` output 1 — response strobe, exactly one cycle after `req_valid`.
- `rsp_rdata` output 32 — read data, valid with `rsp_valid`; 0 for writes/errors.
- `rsp_err` output 1 — unmapped or misaligned address, valid with `rsp_valid`.
- `mtime_o` output 64 — current `mtime`, for the `time` CSR shadow.
- `mtip_o` output `NUM_CMP` — per-channel timer interrupt pending.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 CTRL: bit0 `en`; bits[8+PRESCALE_W-1:8] `div`; other bits read 0, ignore writes.
  - 0x04 MTIME_LO; 0x08 MTIME_HI.
  - 0x0C+8·i MTIMECMP_LO[i]; 0x10+8·i MTIMECMP_HI[i], for i < NUM_CMP.
- Anything else in or out of window, or `req_addr[1:0]`≠0 → `rsp_err`=1, no state change.
- Prescaler: counter `pcnt` runs 0..`div`; `tick` when `pcnt`==`div` and `en`, then `pcnt` wraps to 0. `div`=0 → tick every cycle. `pcnt` held at 0 while `en`=0. Writing CTRL clears `pcnt`.
- `mtime` += 1 on `tick`, wrapping 2^64−1 → 0.
- Write to MTIME_LO/HI replaces that half; the other half holds. No increment in that cycle; the write wins over a coincident tick.
- Atomic read: reading MTIME_LO returns live low word and snapshots live high word into `hi_shadow`. Reading MTIME_HI returns `hi_shadow`. Write to MTIME_HI also loads `hi_shadow`.
- MTIMECMP writes replace the addressed half.
- `mtip_o[i]` = registered (`mtime` ≥ `mtimecmp[i]`), unsigned 64-bit compare. Level-sensitive; cleared only by raising `mtimecmp[i]` or lowering `mtime`.
- Reads of MTIMECMP/CTRL return current register value.

## Timing
- Reset values: `mtime`=0, `mtimecmp[i]`=64'hFFFF_FFFF_FFFF_FFFF, `en`=1, `div`=0, `pcnt`=0, `hi_shadow`=0, `mtip_o`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Response latency fixed at 1 cycle; no backpressure. Back-to-back requests every cycle are accepted.
- Read data samples register state at the request edge; a write issued in cycle N is visible to a read issued in N+1.
- Write takes effect at the request edge. `mtip_o` reflects it one cycle later, so 2 edges from `req_valid` to `mtip_o` change.
- `mtip_o` lags `mtime` by 1 cycle.
- `mtime_o` is the register output, zero latency.
- Reset asserted mid-operation immediately clears all state and outputs. Any in-flight response is dropped.

## Test plan
- Reset, `div`=0, `en`=1, 10 idle cycles → MTIME_LO reads 10 (±1 for request cycle), `mtip_o`=0.
- Write CTRL = `en`=1, `div`=3 → `mtime` increments once every 4 cycles. Write CTRL `en`=0 → `mtime` frozen across 20 cycles.
- Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE, `div`=0. Read LO then HI across the carry → LO=0xFFFF_FFFF-range value and HI=0 (snapshot, not 1). Next LO/HI pair shows HI=1.
- `NUM_CMP`=2: set `mtimecmp[0]`=100, `mtimecmp[1]`=200, `mtime`=0 → `mtip_o[0]` rises the cycle after `mtime`=100, `mtip_o[1]` after 200. Writing `mtimecmp[0]`=1000 clears `mtip_o[0]` 2 edges after the request.
- Access BASE_ADDR+0x40 (unmapped) and BASE_ADDR+0x06 (misaligned) → `rsp_err`=1, `rsp_rdata`=0, no register changes.
- Set `mtime`=2^64−1, tick → `mtime`=0 and `mtip_o` for `mtimecmp`=5 drops. Assert `rst_n`=0 mid-count → all outputs at reset values the same cycle.
